// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder: access-size codes, response
// FSM state constants, queue-entry field widths and the byte-merge helper.
package data_sram_responder_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam int SIZE_W = 2;

   localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
   localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
   localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
   localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

   // Head timer: LATENCY-1 (max 14) plus up to 3 random extra cycles.
   localparam int TIMER_W = 5;

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] w;
      w = old_word;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) w[8*b +: 8] = new_word[8*b +: 8];
      end
      return w;
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous request FIFO for the data SRAM responder. Exposes the head entry
// and the entry behind it so the next head's timer can be loaded on the pop edge.
module resp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [WIDTH-1:0] next,
   output logic             full,
   output logic             empty,
   output logic             more
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [PTR_W:0]   rd_ptr_inc;

   assign rd_ptr_inc = rd_ptr + 1'b1;
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign more       = !empty && (rd_ptr_inc != wr_ptr);
   assign head       = mem[rd_ptr[PTR_W-1:0]];
   assign next       = mem[rd_ptr_inc[PTR_W-1:0]];

   // Entry storage; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= din;
   end

   // Pointer update; push and pop in one cycle leave occupancy unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr_inc;
      end
   end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: queues initiator requests and answers each one in order
// with a one-cycle data_ok pulse no sooner than LATENCY cycles after acceptance.
// Optional macro RESP_RANDOM_DELAY_EN: LFSR-driven addr_ok gating and 0..3
// extra cycles on every head timer load.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | queue empty, nothing to answer
// WAIT    | head timer counting down toward its response cycle
// RESP    | data_ok driven for the head, head retired this cycle
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   // Acceptance timestamps must span the longest possible wait in the queue.
   localparam int STAMP_W = $clog2((QDEPTH + 1) * (LATENCY + 4)) + 1;
   localparam int ENTRY_W = STAMP_W + 1 + SIZE_W + STRB_W + ADDR_W + DATA_W;
   localparam logic [TIMER_W-1:0] LOAD_BASE = TIMER_W'(LATENCY - 1);

   logic [STATE_W-1:0] state;
   logic [TIMER_W-1:0] timer;
   logic [STAMP_W-1:0] now;
   logic [DATA_W-1:0]  mem [2**ADDR_W];

   logic               push;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_more;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] head_entry;
   logic [ENTRY_W-1:0] next_entry;

   logic [STAMP_W-1:0] head_stamp;
   logic               head_wr;
   logic [SIZE_W-1:0]  head_size;
   logic [STRB_W-1:0]  head_strb;
   logic [ADDR_W-1:0]  head_idx;
   logic [DATA_W-1:0]  head_wdata;
   logic [STAMP_W-1:0] next_stamp;

   logic               ok_gate;
   logic [TIMER_W-1:0] rnd_extra;
   logic [TIMER_W-1:0] load_fresh;
   logic [STAMP_W-1:0] load_wide;
   logic [STAMP_W-1:0] src_stamp;
   logic [STAMP_W-1:0] elapsed;
   logic [TIMER_W-1:0] head_load;
   logic [STATE_W-1:0] start_state;

   logic               unused_bits;

`ifdef RESP_RANDOM_DELAY_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR (taps 16,14,13,11), free-running every cycle.
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign ok_gate   = lfsr[0];
   assign rnd_extra = {3'b000, lfsr[2:1]};
`else
   assign ok_gate   = 1'b1;
   assign rnd_extra = '0;
`endif

   assign addr_ok  = !rst && !fifo_full && ok_gate;
   assign push     = req && addr_ok;
   assign data_ok  = !rst && (state == ST_RESP);
   assign fifo_din = {now, wr, size, wstrb, addr[ADDR_W+1:2], wdata};

   assign {head_stamp, head_wr, head_size, head_strb, head_idx, head_wdata} = head_entry;
   assign next_stamp = next_entry[ENTRY_W-1 -: STAMP_W];

   // Size is only carried along; stamps of the head and the ignored address bits are unused.
   assign unused_bits = ^{head_stamp, head_size, addr[31:ADDR_W+2], addr[1:0]};

   resp_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (data_ok),
      .din   (fifo_din),
      .head  (head_entry),
      .next  (next_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .more  (fifo_more)
   );

   assign rdata = (data_ok && !head_wr) ? mem[head_idx] : '0;

   assign load_fresh = LOAD_BASE + rnd_extra;
   assign load_wide  = STAMP_W'(load_fresh);

   // Timer value for the entry that becomes head on this edge, less the
   // cycles it has already spent queued (a fresh push has spent none).
   always_comb begin
      src_stamp = now;
      if (state == ST_RESP && fifo_more) src_stamp = next_stamp;
      elapsed   = now - src_stamp;
      head_load = '0;
      if (elapsed < load_wide) head_load = TIMER_W'(load_wide - elapsed);
      start_state = (head_load == '0) ? ST_RESP : ST_WAIT;
   end

   // Free-running cycle stamp used to age queued entries.
   always_ff @(posedge clk) begin
      if (rst) now <= '0;
      else     now <= now + 1'b1;
   end

   // Response FSM and head timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         timer <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (push) begin
                  state <= start_state;
                  timer <= head_load;
               end
            end
            ST_WAIT: begin
               timer <= timer - 1'b1;
               if (timer <= TIMER_W'(1)) state <= ST_RESP;
            end
            ST_RESP: begin
               if (fifo_more || push) begin
                  state <= start_state;
                  timer <= head_load;
               end else begin
                  state <= ST_IDLE;
                  timer <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               timer <= '0;
            end
         endcase
      end
   end

   // Write heads commit in their response cycle; memory is never reset.
   always_ff @(posedge clk) begin
      if (data_ok && head_wr) mem[head_idx] <= merge_bytes(mem[head_idx], head_wdata, head_strb);
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder (default build, LATENCY=2, QDEPTH=4).
module tb_data_sram_responder;
   import data_sram_responder_pkg::*;

   localparam int ADDR_W  = 8;
   localparam int LATENCY = 2;
   localparam int QDEPTH  = 4;
   localparam int REGION  = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = '0;
   logic [3:0]  wstrb = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   data_sram_responder #(
      .ADDR_W  (ADDR_W),
      .LATENCY (LATENCY),
      .QDEPTH  (QDEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wr      (wr),
      .size    (size),
      .wstrb   (wstrb),
      .addr    (addr),
      .wdata   (wdata),
      .addr_ok (addr_ok),
      .data_ok (data_ok),
      .rdata   (rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] data;
      bit          is_wr;
      int          idx;
      logic [31:0] wd;
      logic [3:0]  strb;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem_spec   [2**ADDR_W];
   logic [31:0] mem_commit [2**ADDR_W];
   logic        exp_aok = 1'b0;
   int          checks = 0;
   int          failures = 0;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] w;
      w = o;
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = n[8*b +: 8];
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares whenever the DUT presents a response, and flags
   // responses that were due but never appeared.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check("rst_addr_ok", 32'(addr_ok), 32'd0);
         check("rst_data_ok", 32'(data_ok), 32'd0);
         check("rst_rdata", rdata, 32'd0);
      end else begin
         check("addr_ok", 32'(addr_ok), 32'(exp_aok));
         if (data_ok) begin
            if (sb.size() == 0) begin
               check("spurious_data_ok", 32'(data_ok), 32'd0);
            end else begin
               e = sb[0];
               sb.delete(0);
               check("resp_cycle", cyc, e.due);
               check("rdata", rdata, e.data);
               if (e.is_wr) mem_commit[e.idx] = merge(mem_commit[e.idx], e.wd, e.strb);
            end
         end else begin
            check("rdata_idle", rdata, 32'd0);
            if (sb.size() != 0 && sb[0].due <= cyc) begin
               e = sb[0];
               sb.delete(0);
               check("missing_data_ok", 32'(data_ok), 32'd1);
               if (e.is_wr) mem_commit[e.idx] = merge(mem_commit[e.idx], e.wd, e.strb);
            end
         end
      end
   end

   // Presents one cycle of stimulus (called just after a rising edge) and,
   // if the request will be accepted, pushes its expected response.
   task automatic drive_cycle(input bit v, input bit w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s, output bit acc);
      exp_t        e;
      logic [31:0] sz;
      sz    = $urandom_range(0, 2);
      req   = v;
      wr    = w;
      addr  = a;
      wdata = d;
      wstrb = s;
      size  = (sz == 0) ? SIZE_BYTE : (sz == 1) ? SIZE_HALF : SIZE_WORD;
      exp_aok = (sb.size() < QDEPTH);
      acc = v && exp_aok;
      if (acc) begin
         e.idx   = int'(a[ADDR_W+1:2]);
         e.is_wr = w;
         e.wd    = d;
         e.strb  = s;
         e.due   = cyc + LATENCY;
         if (sb.size() != 0 && sb[$].due + 1 > e.due) e.due = sb[$].due + 1;
         if (w) begin
            mem_spec[e.idx] = merge(mem_spec[e.idx], d, s);
            e.data = 32'd0;
         end else begin
            e.data = mem_spec[e.idx];
         end
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, acc);
   endtask

   task automatic do_reset(input int n);
      rst     = 1'b1;
      req     = 1'b0;
      exp_aok = 1'b0;
      sb.delete();
      mem_spec = mem_commit;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr(input int idx);
      logic [31:0] a;
      a = $urandom();
      a[ADDR_W+1:2] = idx[ADDR_W-1:0];
      return a;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int got;
      #1;
      do_reset(3);

      for (int i = 0; i < REGION; i++)
         drive_cycle(1'b1, 1'b1, rand_addr(i), $urandom(), 4'hF, acc);
      idle(5);

      drive_cycle(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
      idle(2);
      drive_cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, acc);
      idle(4);

      drive_cycle(1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF, acc);
      drive_cycle(1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h2, acc);
      drive_cycle(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, acc);
      idle(4);

      drive_cycle(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, acc);
      drive_cycle(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, acc);
      idle(4);

      got = 0;
      for (int i = 0; i < 10 && got < 5; i++) begin
         drive_cycle(1'b1, 1'b0, rand_addr(got * 3), 32'h0, 4'h0, acc);
         if (acc) got++;
      end
      idle(8);

      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, rand_addr(4 + 4 * i), 32'h0, 4'h0, acc);
      do_reset(2);
      idle(4);
      drive_cycle(1'b1, 1'b1, 32'h10, 32'h01234567, 4'hF, acc);
      drive_cycle(1'b1, 1'b1, 32'h10, 32'h89ABCDEF, 4'hF, acc);
      do_reset(2);
      idle(4);
      drive_cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, acc);
      idle(4);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset($urandom_range(1, 3));
         end else begin
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        rand_addr($urandom_range(0, REGION - 1)), $urandom(),
                        4'($urandom_range(0, 15)), acc);
         end
      end
      idle(10);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
